// File: rtl/prbs_point_gen.sv
// Pseudo-random (x,y) sample source: two 32-bit Galois LFSRs, a 2-entry output FIFO and a run controller.
// Optional PRBS_STATS_EN adds saturating accept/stall counters (acc_cnt, stall_cnt).
module prbs_point_gen #(
    parameter int          COORD_W = 16,
    parameter logic [31:0] SEED_A  = 32'hACE12468,
    parameter logic [31:0] SEED_B  = 32'h13579BDF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [31:0]        num_samples,
    input  logic               seed_load,
    input  logic [31:0]        seed_a,
    input  logic [31:0]        seed_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic               busy,
`ifdef PRBS_STATS_EN
    output logic [31:0]        acc_cnt,
    output logic [31:0]        stall_cnt,
`endif
    output logic               done
);

    localparam logic [31:0] POLY = 32'h80200003;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } pair_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return (l >> 1) ^ (l[0] ? POLY : 32'h0);
    endfunction

    state_t      state_q;
    logic [31:0] gen_cnt_q;
    logic [31:0] num_q;
    logic        busy_q;
    logic        done_q;

    logic [31:0] lfsr_a_q, lfsr_a_d;
    logic [31:0] lfsr_b_q, lfsr_b_d;
    pair_t       head_q, head_d;
    pair_t       tail_q, tail_d;
    logic [1:0]  fifo_cnt_q, fifo_cnt_d;

    logic  ctrl_idle;
    logic  honour_start;
    logic  honour_seed;
    logic  honour_abort;
    logic  pop;
    logic  gen;
    logic  last_gen;
    pair_t din;

    assign ctrl_idle    = (state_q == S_IDLE) || (state_q == S_DONE);
    assign honour_start = ctrl_idle && start;
    assign honour_seed  = ctrl_idle && seed_load;
    assign honour_abort = !ctrl_idle && abort;
    assign pop          = (fifo_cnt_q != 2'd0) && out_ready;
    assign gen          = (state_q == S_RUN) && !abort && ((fifo_cnt_q != 2'd2) || pop);
    assign last_gen     = gen && (num_q != 32'd0) && (gen_cnt_q + 32'd1 == num_q);
    assign din          = '{x: lfsr_a_q[COORD_W-1:0], y: lfsr_b_q[COORD_W-1:0]};

    // NOTE: every always_comb output gets a hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        lfsr_a_d   = lfsr_a_q;
        lfsr_b_d   = lfsr_b_q;
        head_d     = head_q;
        tail_d     = tail_q;
        fifo_cnt_d = fifo_cnt_q;

        if (honour_seed) begin
            lfsr_a_d = (seed_a == 32'd0) ? SEED_A : seed_a;
            lfsr_b_d = (seed_b == 32'd0) ? SEED_B : seed_b;
        end else if (gen) begin
            lfsr_a_d = lfsr_step(lfsr_a_q);
            lfsr_b_d = lfsr_step(lfsr_b_q);
        end

        // Shift-style FIFO: head drives the outputs directly and simply holds when emptied.
        if (honour_abort) begin
            fifo_cnt_d = 2'd0;
        end else begin
            case (fifo_cnt_q)
                2'd0: begin
                    if (gen) begin
                        head_d     = din;
                        fifo_cnt_d = 2'd1;
                    end
                end
                2'd1: begin
                    case ({gen, pop})
                        2'b11: head_d = din;
                        2'b10: begin
                            tail_d     = din;
                            fifo_cnt_d = 2'd2;
                        end
                        2'b01: fifo_cnt_d = 2'd0;
                        default: ;
                    endcase
                end
                default: begin
                    if (pop) begin
                        head_d = tail_q;
                        if (gen) tail_d = din;
                        else     fifo_cnt_d = 2'd1;
                    end
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_a_q   <= SEED_A;
            lfsr_b_q   <= SEED_B;
            head_q     <= '0;
            tail_q     <= '0;
            fifo_cnt_q <= 2'd0;
        end else begin
            lfsr_a_q   <= lfsr_a_d;
            lfsr_b_q   <= lfsr_b_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            gen_cnt_q <= 32'd0;
            num_q     <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q   <= S_RUN;
                        gen_cnt_q <= 32'd0;
                        num_q     <= num_samples;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        if (gen) gen_cnt_q <= gen_cnt_q + 32'd1;
                        if (last_gen) state_q <= S_DRAIN;
                    end
                end
                default: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (fifo_cnt_d == 2'd0) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef PRBS_STATS_EN
    logic [31:0] acc_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_cnt_q   <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else if (honour_start) begin
            acc_cnt_q   <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            if (pop && (acc_cnt_q != 32'hFFFFFFFF))
                acc_cnt_q <= acc_cnt_q + 32'd1;
            if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFFFFFF))
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign acc_cnt   = acc_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

    assign out_valid = (fifo_cnt_q != 2'd0);
    assign out_x     = head_q.x;
    assign out_y     = head_q.y;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_prbs_point_gen.sv
// Randomized bench for prbs_point_gen: accepted pairs are scored in order against an LFSR sequence model.
module tb_prbs_point_gen;
    localparam int          COORD_W = 16;
    localparam logic [31:0] DEF_A   = 32'hACE12468;
    localparam logic [31:0] DEF_B   = 32'h13579BDF;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               abort;
    logic [31:0]        num_samples;
    logic               seed_load;
    logic [31:0]        seed_a;
    logic [31:0]        seed_b;
    logic               out_valid;
    logic               out_ready;
    logic [COORD_W-1:0] out_x;
    logic [COORD_W-1:0] out_y;
    logic               busy;
    logic               done;
`ifdef PRBS_STATS_EN
    logic [31:0]        acc_cnt;
    logic [31:0]        stall_cnt;
`endif

    prbs_point_gen #(.COORD_W(COORD_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .num_samples(num_samples), .seed_load(seed_load),
        .seed_a(seed_a), .seed_b(seed_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .busy(busy),
`ifdef PRBS_STATS_EN
        .acc_cnt(acc_cnt), .stall_cnt(stall_cnt),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: the pair stream is the LFSR sequence from the current seed, one entry per accepted pair.
    logic [31:0] ref_a, ref_b;
    int          accepted;

    function automatic logic [31:0] lfsr_next(input logic [31:0] l);
        logic [31:0] taps = 32'h80200003;
        return l[0] ? ((l >> 1) ^ taps) : (l >> 1);
    endfunction

    task automatic model_seed(input logic [31:0] a, input logic [31:0] b);
        ref_a = (a == 32'd0) ? DEF_A : a;
        ref_b = (b == 32'd0) ? DEF_B : b;
    endtask

    task automatic tick();
        if (out_valid && out_ready) begin
            check("pair_x", out_x, ref_a[COORD_W-1:0]);
            check("pair_y", out_y, ref_b[COORD_W-1:0]);
            ref_a = lfsr_next(ref_a);
            ref_b = lfsr_next(ref_b);
            accepted++;
        end
        @(negedge clk);
    endtask

    task automatic start_run(input logic [31:0] n, input logic do_seed,
                             input logic [31:0] sa, input logic [31:0] sb);
        start       = 1'b1;
        num_samples = n;
        seed_load   = do_seed;
        seed_a      = sa;
        seed_b      = sb;
        if (do_seed) model_seed(sa, sb);
        accepted = 0;
        tick();
        start     = 1'b0;
        seed_load = 1'b0;
    endtask

    task automatic finish_run(input int n);
        int c = 0;
        while (!done && c < 2000) begin
            out_ready = ($urandom_range(3, 0) != 0);
            if (c == 3 && busy) begin
                start       = 1'b1;
                seed_load   = 1'b1;
                seed_a      = $urandom;
                seed_b      = $urandom;
                num_samples = n + 7;
            end
            tick();
            start     = 1'b0;
            seed_load = 1'b0;
            c++;
        end
        check("run_done_in_budget", done, 1);
        check("accepted_count", accepted, n);
        check("busy_after_done", busy, 0);
        check("valid_after_done", out_valid, 0);
    endtask

    initial begin
        rst = 1'b1; start = 0; abort = 0; num_samples = 0;
        seed_load = 0; seed_a = 0; seed_b = 0; out_ready = 0;
        accepted = 0;
        model_seed(32'd0, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            out_ready = i[0];
            tick();
            check("rst_valid", out_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_xy", {out_x, out_y}, 0);
        end

        // Directed: seed_a = 1, three pairs at full throughput.
        out_ready = 1'b1;
        start_run(3, 1'b1, 32'd1, 32'h0BADF00D);
        check("lat_valid_after_e0", out_valid, 0);
        check("lat_busy_after_e0", busy, 1);
        tick();
        check("seq_valid0", out_valid, 1);
        check("seq_x0", out_x, 16'h0001);
        tick();
        check("seq_x1", out_x, 16'h0003);
        tick();
        check("seq_x2", out_x, 16'h0002);
        tick();
        check("seq_done", done, 1);
        check("seq_valid_end", out_valid, 0);
        check("seq_hold_x", out_x, 16'h0002);
        check("seq_count", accepted, 3);

        // Zero seed falls back to the default seed.
        start_run(1, 1'b1, 32'd0, 32'd0);
        tick();
        check("zero_seed_x", out_x, 16'h2468);
        finish_run(1);

        // Back-pressure: FIFO fills, head holds, then drains in order.
        out_ready = 1'b0;
        start_run(5, 1'b1, $urandom | 32'd1, $urandom);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i >= 1) begin
                check("bp_valid", out_valid, 1);
                check("bp_head_x", out_x, ref_a[COORD_W-1:0]);
                check("bp_busy", busy, 1);
            end
        end
        out_ready = 1'b1;
        for (int c = 0; c < 50 && accepted < 5; c++) tick();
        check("bp_accepted", accepted, 5);
        check("bp_done_after_last_pop", done, 1);

        // Randomized runs; seeds persist across runs unless reloaded.
        for (int r = 0; r < 8; r++) begin
            int n = $urandom_range(24, 1);
            logic ds = (r == 0) || ($urandom_range(1, 0) == 1);
            start_run(n, ds, $urandom, $urandom);
            finish_run(n);
        end

        // Free-run, abort after 100 accepted pairs.
        start_run(0, 1'b1, $urandom, $urandom);
        for (int c = 0; c < 2000 && accepted < 100; c++) begin
            out_ready = ($urandom_range(3, 0) != 0);
            tick();
        end
        check("free_run_100", accepted, 100);
        check("free_run_busy", busy, 1);
        out_ready = 1'b0;
        abort     = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_valid", out_valid, 0);
        out_ready = 1'b1;
        repeat (3) tick();
        check("idle_after_abort_valid", out_valid, 0);
        check("idle_after_abort_count", accepted, 100);

        // Reset mid-run discards the run and restores the default seeds.
        start_run(10, 1'b1, $urandom, $urandom);
        repeat (4) tick();
        rst = 1'b1;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_xy", {out_x, out_y}, 0);
        @(negedge clk);
        rst = 1'b0;
        model_seed(32'd0, 32'd0);
        start_run(2, 1'b0, 32'd0, 32'd0);
        tick();
        check("post_rst_x", out_x, DEF_A[COORD_W-1:0]);
        finish_run(2);

`ifdef PRBS_STATS_EN
        out_ready = 1'b1;
        start_run(4, 1'b1, $urandom, $urandom);
        for (int c = 0; c < 50 && accepted < 2; c++) tick();
        out_ready = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
        for (int c = 0; c < 50 && !done; c++) tick();
        check("stats_done", done, 1);
        check("stats_acc", acc_cnt, 4);
        check("stats_stall", stall_cnt, 3);
        start_run(2, 1'b0, 32'd0, 32'd0);
        check("stats_acc_clear", acc_cnt, 0);
        check("stats_stall_clear", stall_cnt, 0);
        finish_run(2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
